// File: rtl/mips_load_store_unit_if.sv
// rtl/mips_load_store_unit_if.sv - request/response and data-RAM bundle for the MIPS load/store unit
interface mips_load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_rdata;
  logic              resp_fault;

  logic [ADDR_W-1:0] mem_a;
  logic              mem_we;
  logic [31:0]       mem_wd;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_rd;

  // Datapath/RAM side: issues requests, consumes responses, returns RAM read data.
  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           mem_a, mem_we, mem_wd, mem_byteenable
  );

  // Load/store unit side.
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           mem_a, mem_we, mem_wd, mem_byteenable
  );
endinterface

// File: rtl/mips_load_store_unit.sv
// rtl/mips_load_store_unit.sv - data-side load/store stage; LSU_MISALIGN_TRAP_EN selects trapping on misalignment
module mips_load_store_unit #(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input logic                   clk,
  input logic                   reset,
  mips_load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t            state;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic [31:0]       resp_rdata_r;
  logic              resp_fault_r;
  logic [ADDR_W-1:0] mem_a_r;
  logic              mem_we_r;
  logic [31:0]       mem_wd_r;
  logic [3:0]        mem_be_r;
  logic [1:0]        wait_cnt;

  // Registered request attributes needed after the accept cycle.
  logic              store_r;
  logic [1:0]        size_r;
  logic              sext_r;
  logic [1:0]        off_r;

  // Decoded view of the incoming request.
  logic              dec_legal;
  logic              dec_store;
  logic [1:0]        dec_size;
  logic              dec_sext;
  logic              dec_fault;
  logic [1:0]        dec_off;
  logic [3:0]        dec_be;
  logic [31:0]       dec_wd;

  // Decode op, resolve the effective lane offset and build lane enables/write data.
  always_comb begin
    dec_legal = 1'b1;
    dec_store = 1'b0;
    dec_size  = SZ_BYTE;
    dec_sext  = 1'b0;
    case (bus.req_op)
      4'b0000: begin dec_size = SZ_BYTE; dec_sext = 1'b1; end
      4'b0001: begin dec_size = SZ_HALF; dec_sext = 1'b1; end
      4'b0010: begin dec_size = SZ_WORD; end
      4'b0100: begin dec_size = SZ_BYTE; end
      4'b0101: begin dec_size = SZ_HALF; end
      4'b1000: begin dec_size = SZ_BYTE; dec_store = 1'b1; end
      4'b1001: begin dec_size = SZ_HALF; dec_store = 1'b1; end
      4'b1010: begin dec_size = SZ_WORD; dec_store = 1'b1; end
      default: dec_legal = 1'b0;
    endcase

`ifdef LSU_MISALIGN_TRAP_EN
    dec_off   = bus.req_addr[1:0];
    dec_fault = !dec_legal
              || (dec_size == SZ_HALF && bus.req_addr[0])
              || (dec_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);
`else
    // Misaligned halves/words are silently aligned down rather than trapped.
    case (dec_size)
      SZ_HALF: dec_off = {bus.req_addr[1], 1'b0};
      SZ_WORD: dec_off = 2'b00;
      default: dec_off = bus.req_addr[1:0];
    endcase
    dec_fault = !dec_legal;
`endif

    case (dec_size)
      SZ_BYTE: begin
        dec_be = 4'b0001 << dec_off;
        dec_wd = {4{bus.req_wdata[7:0]}};
      end
      SZ_HALF: begin
        dec_be = dec_off[1] ? 4'b1100 : 4'b0011;
        dec_wd = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        dec_be = 4'b1111;
        dec_wd = bus.req_wdata;
      end
    endcase
  end

  // Pick the addressed lane(s) out of the RAM word and extend to 32 bits.
  function automatic logic [31:0] format_load(input logic [31:0] rd, input logic [1:0] size,
                                              input logic sext, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = off[1] ? rd[31:16] : rd[15:0];
    case (size)
      SZ_BYTE: r = {{24{sext & b[7]}}, b};
      SZ_HALF: r = {{16{sext & h[15]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  // Access sequencer: accept, issue one RAM cycle, wait out read latency, hold response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_fault_r <= 1'b0;
      mem_a_r      <= '0;
      mem_we_r     <= 1'b0;
      mem_wd_r     <= 32'd0;
      mem_be_r     <= 4'd0;
      wait_cnt     <= 2'd0;
      store_r      <= 1'b0;
      size_r       <= SZ_BYTE;
      sext_r       <= 1'b0;
      off_r        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            req_ready_r <= 1'b0;
            if (dec_fault) begin
              resp_valid_r <= 1'b1;
              resp_fault_r <= 1'b1;
              resp_rdata_r <= 32'd0;
              state        <= RESP;
            end else begin
              // RAM-facing outputs are loaded here so they are live for the whole ISSUE cycle.
              mem_a_r  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              mem_we_r <= dec_store;
              mem_be_r <= dec_be;
              mem_wd_r <= dec_wd;
              store_r  <= dec_store;
              size_r   <= dec_size;
              sext_r   <= dec_sext;
              off_r    <= dec_off;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          mem_we_r <= 1'b0;
          mem_be_r <= 4'd0;
          if (store_r) begin
            resp_valid_r <= 1'b1;
            resp_rdata_r <= 32'd0;
            state        <= RESP;
          end else begin
            wait_cnt <= 2'(READ_LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            resp_rdata_r <= format_load(bus.mem_rd, size_r, sext_r, off_r);
            resp_valid_r <= 1'b1;
            state        <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_fault_r <= 1'b0;
            req_ready_r  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready      = req_ready_r;
  assign bus.resp_valid     = resp_valid_r;
  assign bus.resp_rdata     = resp_rdata_r;
  assign bus.resp_fault     = resp_fault_r;
  assign bus.mem_a          = mem_a_r;
  assign bus.mem_we         = mem_we_r;
  assign bus.mem_wd         = mem_wd_r;
  assign bus.mem_byteenable = mem_be_r;

endmodule
